pp_sklansky_sub16_pipe: RTL

PP_SKLANSKY_SUB16_PIPE -- requirements
Module: pp_sklansky_sub16_pipe

---
 rtl/pp_sklansky_sub16_pipe.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/pp_sklansky_sub16_pipe.sv
// Two-stage pipelined 16-bit subtractor built on a Sklansky parallel-prefix
// carry tree. Stage 1 holds 4-bit group generate/propagate. Stage 2 holds the
// difference and the status flags. A valid/ready handshake on both sides
// buffers up to two results.
module pp_sklansky_sub16_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] diff,
    output logic        borrow_out,
    output logic        overflow,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned W = 16;

    // One Sklansky level. Every bit whose index has bit 'lvl' set merges with
    // the top bit of the lower half of its span. Returns {p_new, g_new}.
    function automatic logic [2*W-1:0] sk_level(input logic [W-1:0] g,
                                                input logic [W-1:0] p,
                                                input int unsigned  lvl);
        logic [W-1:0] gn;
        logic [W-1:0] pn;
        int unsigned  j;
        gn = g;
        pn = p;
        for (int unsigned i = 0; i < W; i++) begin
            if (i[lvl]) begin
                j     = ((i >> lvl) << lvl) - 1;
                gn[i] = g[i] | (p[i] & g[j]);
                pn[i] = p[i] & p[j];
            end
        end
        return {pn, gn};
    endfunction

    // Stage-1 combinational signals
    logic [W-1:0] p_bit;
    logic [W-1:0] g_l0, p_l0, g_l1, p_l1, g_l2, p_l2;

    // Stage-1 registers
    logic [W-1:0] g2_q, g2_d, p2_q, p2_d, p_q, p_d;
    logic         a15_q, a15_d, b15_q, b15_d, v1_q, v1_d;

    // Stage-2 combinational signals
    logic [W-1:0] g_l3, p_l3, g_l4, diff_c;
    logic         borrow_c, ovf_c;

    // Stage-2 registers
    logic [W-1:0] diff_q, diff_d;
    logic         borrow_q, borrow_d, ovf_q, ovf_d, v2_q, v2_d;

    logic         load1, load2;

    // Bit generate/propagate of a + ~b, then prefix levels 1-2 (4-bit spans)
    always_comb begin
        p_bit = a ^ ~b;
        g_l0  = a & ~b;
        p_l0  = p_bit;
        // Carry-in of 1 acts as a generate at bit -1, folded into bit 0
        g_l0[0] = g_l0[0] | p_bit[0];
        p_l0[0] = 1'b0;
        {p_l1, g_l1} = sk_level(g_l0, p_l0, 0);
        {p_l2, g_l2} = sk_level(g_l1, p_l1, 1);
    end

    // Prefix levels 3-4, sum XOR and status flags from stage-1 registers
    always_comb begin
        {p_l3, g_l3} = sk_level(g2_q, p2_q, 2);
        g_l4         = W'(sk_level(g_l3, p_l3, 3));
        diff_c       = p_q ^ {g_l4[W-2:0], 1'b1};
        borrow_c     = ~g_l4[W-1];
        ovf_c        = (a15_q != b15_q) && (diff_c[W-1] != a15_q);
    end

    // Handshake: S2 drains or is empty; S1 accepts when it can advance
    always_comb begin
        in_ready = rst_n & (~v1_q | ~v2_q | out_ready);
        load2    = v1_q & (~v2_q | out_ready);
        load1    = in_valid & in_ready;
    end

    // Next-state for both stages; data registers only move on a load
    always_comb begin
        g2_d     = g2_q;
        p2_d     = p2_q;
        p_d      = p_q;
        a15_d    = a15_q;
        b15_d    = b15_q;
        v1_d     = v1_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        v2_d     = v2_q;

        if (load1) begin
            g2_d  = g_l2;
            p2_d  = p_l2;
            p_d   = p_bit;
            a15_d = a[W-1];
            b15_d = b[W-1];
            v1_d  = 1'b1;
        end else if (load2) begin
            v1_d  = 1'b0;
        end

        if (load2) begin
            diff_d   = diff_c;
            borrow_d = borrow_c;
            ovf_d    = ovf_c;
            v2_d     = 1'b1;
        end else if (out_ready) begin
            v2_d     = 1'b0;
        end
    end

    // Pipeline state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g2_q     <= '0;
            p2_q     <= '0;
            p_q      <= '0;
            a15_q    <= 1'b0;
            b15_q    <= 1'b0;
            v1_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            v2_q     <= 1'b0;
        end else begin
            g2_q     <= g2_d;
            p2_q     <= p2_d;
            p_q      <= p_d;
            a15_q    <= a15_d;
            b15_q    <= b15_d;
            v1_q     <= v1_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            v2_q     <= v2_d;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;
    assign out_valid  = v2_q;

endmodule
